// File: rtl/logic_pipe_unit.sv
// logic_pipe_unit: two-stage pipelined four-operand logic cell with valid/ready flow.
// Optional parity output enabled by defining LOGIC_PIPE_PARITY_EN.
module logic_pipe_unit #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_mode,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_c,
  input  logic [WIDTH-1:0] in_d,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_f1,
  output logic [WIDTH-1:0] out_f2,
  output logic [CNT_W-1:0] out_count
`ifdef LOGIC_PIPE_PARITY_EN
  ,
  output logic [1:0]       out_par
`endif
);

  logic             r_v1;
  logic             r_v2;
  logic [1:0]       r_mode1;
  logic [WIDTH-1:0] r_t1;
  logic [WIDTH-1:0] r_t2;
  logic [WIDTH-1:0] r_t3;
  logic [WIDTH-1:0] r_t4;
  logic [WIDTH-1:0] r_f1;
  logic [WIDTH-1:0] r_f2;
  logic [CNT_W-1:0] r_cnt;

  logic             w_rdy1;
  logic             w_rdy2;
  logic             w_acc;
  logic             w_mv;
  logic [WIDTH-1:0] w_f1;
  logic [WIDTH-1:0] w_f2;

  assign w_rdy2   = ~r_v2 | out_ready;
  assign w_rdy1   = ~r_v1 | w_rdy2;
  // Held low while reset is asserted so sources never see a ready unit.
  assign in_ready = w_rdy1 & rst_n;
  assign w_acc    = in_valid & in_ready;
  assign w_mv     = r_v1 & w_rdy2;

  assign out_valid = r_v2;
  assign out_f1    = r_f1;
  assign out_f2    = r_f2;
  assign out_count = r_cnt;

  // Mode-selected combination of the stage-1 partial terms.
  always_comb begin
    w_f1 = '0;
    w_f2 = '0;
    unique case (r_mode1)
      2'b00: begin
        w_f1 = r_t1 | r_t3;
        w_f2 = r_t2 & r_t4;
      end
      2'b01: begin
        w_f1 = r_t1 & r_t3;
        w_f2 = r_t2 | r_t4;
      end
      2'b10: begin
        w_f1 = ~(r_t1 | r_t3);
        w_f2 = ~(r_t2 & r_t4);
      end
      2'b11: begin
        w_f1 = r_t1 ^ r_t2;
        w_f2 = r_t3 ^ r_t4;
      end
      default: begin
        w_f1 = '0;
        w_f2 = '0;
      end
    endcase
  end

  // Stage 1: capture partial terms on accept; drain when S2 takes them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1    <= 1'b0;
      r_mode1 <= 2'b00;
      r_t1    <= '0;
      r_t2    <= '0;
      r_t3    <= '0;
      r_t4    <= '0;
    end else if (w_rdy1) begin
      r_v1 <= w_acc;
      if (w_acc) begin
        r_mode1 <= in_mode;
        r_t1    <= in_a & in_b;
        r_t2    <= in_b | in_c;
        r_t3    <= in_c ^ in_d;
        r_t4    <= ~in_d;
      end
    end
  end

  // Stage 2: result registers, held while downstream stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v2 <= 1'b0;
      r_f1 <= '0;
      r_f2 <= '0;
    end else if (w_rdy2) begin
      r_v2 <= r_v1;
      if (w_mv) begin
        r_f1 <= w_f1;
        r_f2 <= w_f2;
      end
    end
  end

  // Completed output transfers, wrapping naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (r_v2 && out_ready) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

`ifdef LOGIC_PIPE_PARITY_EN
  logic [1:0] r_par;

  assign out_par = r_par;

  // Parity of each result, loaded alongside the stage-2 data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_par <= 2'b00;
    end else if (w_mv) begin
      r_par <= {^w_f2, ^w_f1};
    end
  end
`endif

endmodule

// File: tb/tb_logic_pipe_unit.sv
// tb_logic_pipe_unit: directed table plus stall, wrap, reset and
// random-flow sequences for logic_pipe_unit (WIDTH=4, CNT_W=4).
module tb_logic_pipe_unit;

  localparam int W  = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [1:0]    in_mode = 2'b00;
  logic [W-1:0]  in_a = '0;
  logic [W-1:0]  in_b = '0;
  logic [W-1:0]  in_c = '0;
  logic [W-1:0]  in_d = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_f1;
  logic [W-1:0]  out_f2;
  logic [CW-1:0] out_count;
`ifdef LOGIC_PIPE_PARITY_EN
  logic [1:0]    out_par;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  logic             sb_en = 1'b0;
  logic [2*W-1:0]   q[$];
  logic             prev_stall = 1'b0;
  logic [W-1:0]     prev_f1 = '0;
  logic [W-1:0]     prev_f2 = '0;

  typedef struct {
    logic [1:0]   mode;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] c;
    logic [W-1:0] d;
    logic [W-1:0] f1;
    logic [W-1:0] f2;
  } vec_t;

  vec_t tbl[8];

  logic_pipe_unit #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_c      (in_c),
    .in_d      (in_d),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_f1    (out_f1),
    .out_f2    (out_f2),
    .out_count (out_count)
`ifdef LOGIC_PIPE_PARITY_EN
    ,
    .out_par   (out_par)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [2*W-1:0] ref_f(input logic [1:0] m,
      input logic [W-1:0] a, input logic [W-1:0] b,
      input logic [W-1:0] c, input logic [W-1:0] d);
    logic [W-1:0] t1, t2, t3, t4, f1, f2;
    t1 = a & b;
    t2 = b | c;
    t3 = c ^ d;
    t4 = ~d;
    case (m)
      2'b00:   begin f1 = t1 | t3;    f2 = t2 & t4;    end
      2'b01:   begin f1 = t1 & t3;    f2 = t2 | t4;    end
      2'b10:   begin f1 = ~(t1 | t3); f2 = ~(t2 & t4); end
      default: begin f1 = t1 ^ t2;    f2 = t3 ^ t4;    end
    endcase
    return {f1, f2};
  endfunction

  // Scoreboard: outputs in order, stalled outputs stable, no extras.
  always @(negedge clk) begin
    logic [2*W-1:0] e;
    if (rst_n && sb_en) begin
      if (prev_stall && out_valid) begin
        check("stall_hold_f1", out_f1, prev_f1);
        check("stall_hold_f2", out_f2, prev_f2);
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("sb_extra_output", 1, 0);
        end else begin
          e = q.pop_front();
          check("sb_f1", out_f1, e[2*W-1:W]);
          check("sb_f2", out_f2, e[W-1:0]);
        end
      end
      if (in_valid && in_ready)
        q.push_back(ref_f(in_mode, in_a, in_b, in_c, in_d));
      prev_stall = out_valid & ~out_ready;
      prev_f1    = out_f1;
      prev_f2    = out_f2;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic drive(input vec_t v);
    in_mode  = v.mode;
    in_a     = v.a;
    in_b     = v.b;
    in_c     = v.c;
    in_d     = v.d;
    in_valid = 1'b1;
  endtask

  task automatic do_reset();
    sb_en     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    q.delete();
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_count", out_count, 0);
    check("rst_f1", out_f1, 0);
    check("rst_f2", out_f2, 0);
`ifdef LOGIC_PIPE_PARITY_EN
    check("rst_par", out_par, 0);
`endif
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int waits;
    logic seen;
    logic bad;

    tbl[0] = '{2'b00, 4'hC, 4'hA, 4'h6, 4'h3, 4'hD, 4'hC};
    tbl[1] = '{2'b01, 4'hC, 4'hA, 4'h6, 4'h3, 4'h0, 4'hE};
    tbl[2] = '{2'b10, 4'hC, 4'hA, 4'h6, 4'h3, 4'h2, 4'h3};
    tbl[3] = '{2'b11, 4'hC, 4'hA, 4'h6, 4'h3, 4'h6, 4'h9};
    tbl[4] = '{2'b00, 4'hF, 4'h0, 4'hF, 4'h0, 4'hF, 4'hF};
    tbl[5] = '{2'b11, 4'hF, 4'h0, 4'hF, 4'h0, 4'hF, 4'h0};
    tbl[6] = '{2'b01, 4'h5, 4'h3, 4'h9, 4'hA, 4'h1, 4'hF};
    tbl[7] = '{2'b10, 4'h5, 4'h3, 4'h9, 4'hA, 4'hC, 4'hE};

    // Table: one transaction at a time, latency and results.
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i]);
      @(posedge clk);
      #1 in_valid = 1'b0;
      waits = 0;
      seen  = 1'b0;
      while (!seen && waits < 6) begin
        @(negedge clk);
        waits++;
        seen = out_valid;
      end
      check($sformatf("vec%0d_latency", i), waits, 2);
      check($sformatf("vec%0d_f1", i), out_f1, tbl[i].f1);
      check($sformatf("vec%0d_f2", i), out_f2, tbl[i].f2);
`ifdef LOGIC_PIPE_PARITY_EN
      check($sformatf("vec%0d_par", i), out_par,
            {30'd0, ^tbl[i].f2, ^tbl[i].f1});
`endif
      if (i == 0) begin
        @(negedge clk);
        check("vec0_count", out_count, 1);
      end
      @(posedge clk);
      #1;
    end
    check("table_count", out_count, 8);

    // Back-to-back modes 01,10,11 emerge on consecutive cycles.
    do_reset();
    out_ready = 1'b1;
    drive(tbl[1]);
    @(posedge clk);
    #1 drive(tbl[2]);
    @(posedge clk);
    #1 drive(tbl[3]);
    @(negedge clk);
    check("b2b0_v", out_valid, 1);
    check("b2b0_f", {out_f1, out_f2}, {tbl[1].f1, tbl[1].f2});
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("b2b1_v", out_valid, 1);
    check("b2b1_f", {out_f1, out_f2}, {tbl[2].f1, tbl[2].f2});
    @(negedge clk);
    check("b2b2_v", out_valid, 1);
    check("b2b2_f", {out_f1, out_f2}, {tbl[3].f1, tbl[3].f2});
    @(negedge clk);
    check("b2b_idle", out_valid, 0);

    // Stall: two fill the pipe, third waits, then all drain in order.
    do_reset();
    sb_en = 1'b1;
    drive(tbl[0]);
    @(negedge clk);
    check("stall_rdy0", in_ready, 1);
    @(posedge clk);
    #1 drive(tbl[4]);
    @(negedge clk);
    check("stall_rdy1", in_ready, 1);
    @(posedge clk);
    #1 drive(tbl[6]);
    repeat (3) begin
      @(negedge clk);
      check("stall_full_rdy", in_ready, 0);
      check("stall_out_v", out_valid, 1);
      check("stall_out_f1", out_f1, tbl[0].f1);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    check("stall_release_rdy", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("stall_q_empty", q.size(), 0);
    check("stall_count", out_count, 3);

    // Reset with two transactions in flight.
    out_ready = 1'b0;
    @(posedge clk);
    #1 drive(tbl[1]);
    @(posedge clk);
    #1 drive(tbl[2]);
    @(posedge clk);
    #1 in_valid = 1'b0;
    #2;
    sb_en = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_count", out_count, 0);
    check("midrst_in_ready", in_ready, 0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    bad = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) bad = 1'b1;
    end
    check("midrst_no_emit", bad, 0);
    check("midrst_count_after", out_count, 0);

    // Counter wrap: 17 streamed transfers with CNT_W=4.
    do_reset();
    sb_en = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      in_mode  = 2'($urandom_range(0, 3));
      in_a     = 4'($urandom);
      in_b     = 4'($urandom);
      in_c     = 4'($urandom);
      in_d     = 4'($urandom);
      in_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("wrap_count", out_count, 1);
    check("wrap_q_empty", q.size(), 0);

    // Random valid/ready traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom);
      in_mode   = 2'($urandom_range(0, 3));
      in_a      = 4'($urandom);
      in_b      = 4'($urandom);
      in_c      = 4'($urandom);
      in_d      = 4'($urandom);
      out_ready = 1'($urandom);
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (5) @(negedge clk);
    check("rand_q_empty", q.size(), 0);
    check("rand_idle", out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
